// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem word reads, buffers responses in a small
// FIFO and hands {pc, ir} to decode. Handles redirects (dropping stale fetches) and halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_ir,
  output logic        halted
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StHalted = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] ir_mem [FIFO_DEPTH];
  logic [31:0] pc_mem [FIFO_DEPTH];

  logic          running, redir, accept, push, pop, dropping;
  logic [CntW:0] inflight;

  assign running   = (state_q == StRun);
  assign halted    = (state_q == StHalted);
  assign redir     = running && redirect_valid;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready && !redir;
  assign dropping  = (drop_q != '0);
  assign push      = imem_resp_valid && !dropping && !redir;

  // The slot freed by this cycle's pop is credited so a 2-deep buffer sustains full rate;
  // the matching response cannot arrive before that pop has taken effect.
  assign inflight = {1'b0, cnt_q} + {1'b0, outst_q} - {{CntW{1'b0}}, pop};

  assign imem_req_valid = !rst && running && !redirect_valid && (inflight < DepthW);
  assign imem_addr      = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign out_pc = out_valid ? pc_mem[rd_ptr_q] : 32'h0;
  assign out_ir = out_valid ? ir_mem[rd_ptr_q] : NOP_INSN;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    outst_d   = outst_q + CntW'(accept) - CntW'(imem_resp_valid);

    if (accept) pc_d = pc_q + 32'd4;

    if (redir) begin
      // Everything still outstanding (minus a response landing now) belongs to the old path.
      pc_d      = redirect_pc & 32'hFFFF_FFFC;
      resp_pc_d = redirect_pc & 32'hFFFF_FFFC;
      cnt_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      drop_d    = outst_q - CntW'(imem_resp_valid);
    end else begin
      if (imem_resp_valid && dropping) drop_d = drop_q - CntW'(1);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PtrW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end

    if (running && halt) state_d = StHalted;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      cnt_q     <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      cnt_q     <= cnt_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem[wr_ptr_q] <= imem_resp_data;
      pc_mem[wr_ptr_q] <= resp_pc_q;
    end
  end

endmodule
